// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch sequencer: instruction layout, opcodes and FSM states.
package glitch_pkg;

  localparam int INSTR_W = 12;
  localparam int DELAY_W = 32;

  localparam logic [1:0] OP_SEND  = 2'b00;
  localparam logic [1:0] OP_WAIT  = 2'b01;
  localparam logic [1:0] OP_LDDLY = 2'b10;
  localparam logic [1:0] OP_HALT  = 2'b11;

  localparam int OP_MSB   = 11;
  localparam int OP_LSB   = 10;
  localparam int EN_BIT   = 9;
  localparam int OPND_MSB = 8;
  localparam int OPND_LSB = 1;
  localparam int FLAG_BIT = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_SEND,
    S_GLITCH,
    S_LDWAIT,
    S_WAIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/glitch_sequencer_delay_counter.sv
// Loadable 32-bit down-counter with repeat count; done marks the last stall cycle.
module delay_counter
  import glitch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               cap,
  input  logic [DELAY_W-1:0] cap_val,
  input  logic               go,
  input  logic [7:0]         rpt_in,
  output logic               zero,
  output logic               done
);

  logic [DELAY_W-1:0] dly_q, dly_d;
  logic [DELAY_W-1:0] dcnt_q, dcnt_d;
  logic [7:0]         rpt_q, rpt_d;
  logic               act_q, act_d;

  // dly_q keeps the captured delay so dcnt can be reloaded for each repeat.
  always_comb begin
    dly_d  = dly_q;
    dcnt_d = dcnt_q;
    rpt_d  = rpt_q;
    act_d  = act_q;
    if (cap) begin
      dly_d  = cap_val;
      dcnt_d = cap_val;
      act_d  = 1'b0;
    end else if (go) begin
      dcnt_d = dly_q;
      rpt_d  = (rpt_in == 8'd0) ? 8'd1 : rpt_in;
      act_d  = (dly_q != '0);
    end else if (act_q) begin
      if (dcnt_q > 32'd1) begin
        dcnt_d = dcnt_q - 32'd1;
      end else if (rpt_q > 8'd1) begin
        rpt_d  = rpt_q - 8'd1;
        dcnt_d = dly_q;
      end else begin
        dcnt_d = '0;
        rpt_d  = '0;
        act_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dly_q  <= '0;
      dcnt_q <= '0;
      rpt_q  <= '0;
      act_q  <= 1'b0;
    end else begin
      dly_q  <= dly_d;
      dcnt_q <= dcnt_d;
      rpt_q  <= rpt_d;
      act_q  <= act_d;
    end
  end

  assign zero = (dly_q == '0);
  assign done = act_q && (dcnt_q == 32'd1) && (rpt_q == 8'd1);

endmodule

// File: rtl/glitch_sequencer.sv
// Executes 12-bit program ROM words: emits bytes, fires glitch pulses, stalls on loaded delays, halts.
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int PROG_LEN  = 14,
  parameter int FETCH_LAT = 2,
  parameter int GLITCH_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr,
  input  logic [DELAY_W-1:0] delay_len,
  output logic [7:0]         instr_pt,
  output logic [7:0]         delay_num,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               glitch,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t     state_q, state_d;
  logic [7:0] instr_pt_q, instr_pt_d;
  logic [7:0] delay_num_q, delay_num_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       glitch_q, glitch_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       flag_q, flag_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic [7:0] gcnt_q, gcnt_d;

  logic       adv;
  logic       dc_cap, dc_go, dc_zero, dc_done;
  logic [8:0] nxt_pt;
  logic [1:0] op;
  logic [7:0] operand;

  assign op      = instr[OP_MSB:OP_LSB];
  assign operand = instr[OPND_MSB:OPND_LSB];
  // 9-bit so that 255+1 cannot wrap back into range.
  assign nxt_pt  = {1'b0, instr_pt_q} + 9'd1;

  delay_counter u_delay_counter (
    .clk     (clk),
    .reset   (reset),
    .cap     (dc_cap),
    .cap_val (delay_len),
    .go      (dc_go),
    .rpt_in  (operand),
    .zero    (dc_zero),
    .done    (dc_done)
  );

  always_comb begin
    state_d     = state_q;
    instr_pt_d  = instr_pt_q;
    delay_num_d = delay_num_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    glitch_d    = glitch_q;
    err_d       = err_q;
    flag_d      = flag_q;
    fcnt_d      = fcnt_q;
    gcnt_d      = gcnt_q;
    adv         = 1'b0;
    dc_cap      = 1'b0;
    dc_go       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          err_d      = 1'b0;
          instr_pt_d = '0;
          fcnt_d     = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (fcnt_q == 8'(FETCH_LAT - 1)) state_d = S_EXEC;
        else                              fcnt_d  = fcnt_q + 8'd1;
      end
      S_EXEC: begin
        if (!instr[EN_BIT]) begin
          adv = 1'b1;
        end else begin
          case (op)
            OP_SEND: begin
              out_data_d  = operand;
              out_valid_d = 1'b1;
              flag_d      = instr[FLAG_BIT];
              state_d     = S_SEND;
            end
            OP_LDDLY: begin
              delay_num_d = operand;
              fcnt_d      = '0;
              state_d     = S_LDWAIT;
            end
            OP_WAIT: begin
              if (dc_zero) begin
                adv = 1'b1;
              end else begin
                dc_go   = 1'b1;
                state_d = S_WAIT;
              end
            end
            default: state_d = S_DONE;
          endcase
        end
      end
      S_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (flag_q) begin
            glitch_d = 1'b1;
            gcnt_d   = '0;
            state_d  = S_GLITCH;
          end else begin
            adv = 1'b1;
          end
        end
      end
      S_GLITCH: begin
        if (gcnt_q == 8'(GLITCH_W - 1)) begin
          glitch_d = 1'b0;
          adv      = 1'b1;
        end else begin
          gcnt_d = gcnt_q + 8'd1;
        end
      end
      // The extra cycle past FETCH_LAT lets the delay word settle, matching FETCH+EXEC.
      S_LDWAIT: begin
        if (fcnt_q == 8'(FETCH_LAT)) begin
          dc_cap = 1'b1;
          adv    = 1'b1;
        end else begin
          fcnt_d = fcnt_q + 8'd1;
        end
      end
      S_WAIT: begin
        if (dc_done) adv = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      if (nxt_pt < 9'(PROG_LEN)) begin
        instr_pt_d = nxt_pt[7:0];
        fcnt_d     = '0;
        state_d    = S_FETCH;
      end else begin
        err_d   = 1'b1;
        state_d = S_DONE;
      end
    end

    busy_d = !(state_d inside {S_IDLE, S_DONE});
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      instr_pt_q  <= '0;
      delay_num_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      glitch_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      flag_q      <= 1'b0;
      fcnt_q      <= '0;
      gcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      instr_pt_q  <= instr_pt_d;
      delay_num_q <= delay_num_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      glitch_q    <= glitch_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      flag_q      <= flag_d;
      fcnt_q      <= fcnt_d;
      gcnt_q      <= gcnt_d;
    end
  end

  assign instr_pt  = instr_pt_q;
  assign delay_num = delay_num_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign glitch    = glitch_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer with a two-stage registered ROM model.
module tb_glitch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] instr;
  logic [31:0] delay_len;
  logic [7:0]  instr_pt, delay_num, out_data;
  logic        out_valid, out_ready, glitch, busy, done, err;

  logic [11:0] rom  [0:255];
  logic [31:0] dtab [0:255];
  logic [11:0] rom_s1;
  logic [31:0] dly_s1;

  int total = 0;
  int bad   = 0;

  localparam logic [11:0] I_HALT = 12'hE00;

  glitch_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .instr     (instr),
    .delay_len (delay_len),
    .instr_pt  (instr_pt),
    .delay_num (delay_num),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .glitch    (glitch),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    rom_s1    <= rom[instr_pt];
    instr     <= rom_s1;
    dly_s1    <= dtab[delay_num];
    delay_len <= dly_s1;
  end

  function automatic logic [11:0] enc(input logic [1:0] op, input logic en,
                                      input logic [7:0] opnd, input logic fl);
    return {op, en, opnd, fl};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) begin
      rom[i]  = I_HALT;
      dtab[i] = 32'h0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset();
    logic [37:0] obs;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    obs = {instr_pt, delay_num, out_data, out_valid, glitch, busy, done, err};
    total++;
    if (obs !== 38'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", obs);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_send_halt(input string tag, input bit check_first);
    int beats = 0;
    logic [7:0] data = 8'h00;
    logic [7:0] maxpt = 8'h00;
    logic [7:0] first = 8'hFF;
    int c;
    clear_prog();
    rom[0] = enc(2'b00, 1'b1, 8'h84, 1'b0);
    rom[1] = I_HALT;
    out_ready = 1'b1;
    pulse_start();
    for (c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 0) first = instr_pt;
      if (out_valid) begin beats++; data = out_data; end
      if (instr_pt > maxpt) maxpt = instr_pt;
      if (done) break;
    end
    total++;
    if (c == 200) begin bad++; $display("FAIL %s_timeout: done never rose", tag); end
    if (check_first) begin
      total++;
      if (first !== 8'h00) begin bad++; $display("FAIL %s_first_pt: got %0d want 0", tag, first); end
    end
    total++;
    if (beats != 1 || data !== 8'h84) begin
      bad++; $display("FAIL %s_beat: got beats=%0d data=%h want 1 beat of 84", tag, beats, data);
    end
    total++;
    if (maxpt !== 8'd1 || instr_pt !== 8'd1) begin
      bad++; $display("FAIL %s_ptr: got max=%0d final=%0d want 1", tag, maxpt, instr_pt);
    end
    total++;
    if ({done, err, busy} !== 3'b100) begin
      bad++; $display("FAIL %s_status: got done,err,busy=%b want 100", tag, {done, err, busy});
    end
    out_ready = 1'b0;
  endtask

  task automatic test_send_glitch();
    int c;
    int gcount = 0;
    bit stable = 1'b1;
    clear_prog();
    rom[0] = enc(2'b00, 1'b1, 8'h80, 1'b1);
    out_ready = 1'b0;
    pulse_start();
    for (c = 0; c < 50; c++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    total++;
    if (c == 50) begin bad++; $display("FAIL glitch_valid_timeout: out_valid never rose"); end
    for (int i = 0; i < 5; i++) begin
      if (!(out_valid === 1'b1 && out_data === 8'h80 && glitch === 1'b0)) stable = 1'b0;
      @(negedge clk);
    end
    total++;
    if (!stable) begin bad++; $display("FAIL send_hold: out_valid/out_data not stable, got %b/%h want 1/80", out_valid, out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({out_valid, glitch} !== 2'b01) begin
      bad++; $display("FAIL glitch_start: got valid,glitch=%b want 01", {out_valid, glitch});
    end
    for (int i = 0; i < 20; i++) begin
      if (!glitch) break;
      gcount++;
      @(negedge clk);
    end
    total++;
    if (gcount != 4) begin bad++; $display("FAIL glitch_width: got %0d want 4", gcount); end
    out_ready = 1'b0;
    for (c = 0; c < 50 && !done; c++) @(negedge clk);
    total++;
    if ({done, err} !== 2'b10) begin bad++; $display("FAIL glitch_end: got done,err=%b want 10", {done, err}); end
  endtask

  task automatic test_delay(input string tag, input logic [31:0] dl, input int exp_dwell,
                            input bit poke_start);
    int dwell = 0;
    int c;
    clear_prog();
    rom[0] = enc(2'b10, 1'b1, 8'd1, 1'b0);
    rom[1] = enc(2'b01, 1'b1, 8'd3, 1'b0);
    rom[2] = I_HALT;
    dtab[0] = 32'h7;
    dtab[1] = dl;
    pulse_start();
    for (c = 0; c < 400; c++) begin
      @(negedge clk);
      if (instr_pt == 8'd1 && busy) dwell++;
      start = poke_start && (dwell == 20);
      if (done) break;
    end
    start = 1'b0;
    total++;
    if (c == 400) begin bad++; $display("FAIL %s_timeout: done never rose", tag); end
    total++;
    if (dwell != exp_dwell) begin bad++; $display("FAIL %s_stall: got dwell %0d want %0d", tag, dwell, exp_dwell); end
    total++;
    if (delay_num !== 8'd1 || instr_pt !== 8'd2 || err !== 1'b0) begin
      bad++; $display("FAIL %s_regs: got delay_num=%0d pt=%0d err=%b want 1 2 0", tag, delay_num, instr_pt, err);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] maxpt = 8'h00;
    bit saw_valid = 1'b0;
    int c;
    clear_prog();
    for (int i = 0; i < 14; i++) rom[i] = enc(2'b00, 1'b0, 8'h84, 1'b0);
    out_ready = 1'b1;
    pulse_start();
    for (c = 0; c < 300; c++) begin
      @(negedge clk);
      if (instr_pt > maxpt) maxpt = instr_pt;
      if (out_valid) saw_valid = 1'b1;
      if (done) break;
    end
    out_ready = 1'b0;
    total++;
    if (maxpt !== 8'd13 || instr_pt !== 8'd13) begin
      bad++; $display("FAIL overrun_ptr: got max=%0d final=%0d want 13", maxpt, instr_pt);
    end
    total++;
    if ({done, err, busy} !== 3'b110) begin
      bad++; $display("FAIL overrun_status: got done,err,busy=%b want 110", {done, err, busy});
    end
    total++;
    if (saw_valid) begin bad++; $display("FAIL overrun_nop_valid: got out_valid=1 want 0"); end
  endtask

  task automatic test_nop();
    bit saw_valid = 1'b0;
    int c;
    clear_prog();
    rom[0] = 12'h000;
    rom[1] = I_HALT;
    pulse_start();
    for (c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
      if (done) break;
    end
    total++;
    if (saw_valid) begin bad++; $display("FAIL nop_valid: got out_valid=1 want 0"); end
    total++;
    if (instr_pt !== 8'd1 || {done, err} !== 2'b10) begin
      bad++; $display("FAIL nop_advance: got pt=%0d done,err=%b want 1 10", instr_pt, {done, err});
    end
  endtask

  task automatic test_reset_mid();
    logic [37:0] obs;
    int c;
    clear_prog();
    rom[0] = enc(2'b10, 1'b1, 8'd1, 1'b0);
    rom[1] = enc(2'b01, 1'b1, 8'd3, 1'b0);
    dtab[1] = 32'h10;
    pulse_start();
    repeat (15) @(negedge clk);
    #2 reset = 1'b0;
    #1 obs = {instr_pt, delay_num, out_data, out_valid, glitch, busy, done, err};
    total++;
    if (obs !== 38'h0) begin bad++; $display("FAIL reset_mid_wait: got %h want 0", obs); end
    @(negedge clk) reset = 1'b1;

    clear_prog();
    rom[0] = enc(2'b00, 1'b1, 8'h55, 1'b1);
    out_ready = 1'b0;
    pulse_start();
    for (c = 0; c < 50; c++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    #2 reset = 1'b0;
    #1 obs = {instr_pt, delay_num, out_data, out_valid, glitch, busy, done, err};
    total++;
    if (c == 50 || obs !== 38'h0) begin
      bad++; $display("FAIL reset_mid_send: got %h (wait %0d) want 0", obs, c);
    end
    @(negedge clk) reset = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if ({busy, out_valid, glitch, instr_pt} !== 11'h0) begin
      bad++; $display("FAIL reset_no_resume: got busy,valid,glitch,pt=%h want 0", {busy, out_valid, glitch, instr_pt});
    end
    test_send_halt("restart", 1'b1);
  endtask

  initial begin
    start     = 1'b0;
    out_ready = 1'b0;
    clear_prog();
    test_reset();
    test_send_halt("send_halt", 1'b1);
    test_send_glitch();
    test_delay("delay16", 32'h10, 51, 1'b1);
    test_delay("delay0", 32'h0, 3, 1'b0);
    test_overrun();
    test_nop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
